// File: rtl/scroll_controller_pkg.sv
// Shared constants and types for the two-digit message scroller.
package scroll_controller_pkg;

  localparam int IDX_W              = 5;
  localparam int DEF_TICKS_PER_STEP = 25000000;
  localparam int DEF_MSG_LEN        = 16;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_AUTO   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // Counter width for a divide-by-ticks counter; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running tick counter with enable and clear; pulses o_Tc on its last count.
module tick_divider
  import scroll_controller_pkg::*;
#(
  parameter int TICKS = DEF_TICKS_PER_STEP
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_En,
  input  logic i_Clr,
  output logic o_Tc
);

  localparam int            CW     = cnt_width(TICKS);
  localparam logic [CW-1:0] TC_VAL = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over a terminal count so a cleared cycle never advances.
  assign o_Tc = i_En && !i_Clr && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr)     cnt_d = '0;
    else if (i_En) cnt_d = o_Tc ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scroll_controller.sv
// Scroll FSM (manual / auto / hold) and message position register.
module scroll_controller
  import scroll_controller_pkg::*;
#(
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int MSG_LEN        = DEF_MSG_LEN
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Step,
  input  logic             i_Run,
  input  logic             i_Hold,
  output logic [IDX_W-1:0] o_Left_Index,
  output logic [IDX_W-1:0] o_Right_Index,
  output logic             o_Update,
  output logic             o_Mode
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             ret_auto_q, ret_auto_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             upd_q, upd_d;
  logic             cnt_en, cnt_clr, step_adv, tc, advance;

  tick_divider #(.TICKS(TICKS_PER_STEP)) u_tick (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_En    (cnt_en),
    .i_Clr   (cnt_clr),
    .o_Tc    (tc)
  );

  // Priority inside each state: hold, then run, then step.
  always_comb begin
    state_d    = state_q;
    ret_auto_d = ret_auto_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    step_adv   = 1'b0;
    case (state_q)
      S_MANUAL: begin
        if (i_Hold) begin
          state_d    = S_HOLD;
          ret_auto_d = 1'b0;
        end else if (i_Run) begin
          state_d = S_AUTO;
          cnt_clr = 1'b1;
        end else if (i_Step) begin
          step_adv = 1'b1;
        end
      end
      S_AUTO: begin
        if (i_Hold) begin
          state_d    = S_HOLD;
          ret_auto_d = 1'b1;
        end else if (i_Run) begin
          state_d = S_MANUAL;
          cnt_clr = 1'b1;
        end else if (i_Step) begin
          step_adv = 1'b1;
          cnt_clr  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_HOLD: begin
        // Step/run are dropped here; counting resumes in the release cycle.
        if (!i_Hold) begin
          state_d = ret_auto_q ? S_AUTO : S_MANUAL;
          cnt_en  = ret_auto_q;
        end
      end
      default: state_d = S_MANUAL;
    endcase
  end

  // tc is gated off whenever step clears the counter, so at most one advance.
  assign advance = step_adv | tc;

  always_comb begin
    pos_d = advance ? wrap_inc(pos_q) : pos_q;
    upd_d = advance;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= S_MANUAL;
      ret_auto_q <= 1'b0;
      pos_q      <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_auto_q <= ret_auto_d;
      pos_q      <= pos_d;
      upd_q      <= upd_d;
    end
  end

  assign o_Left_Index  = pos_q;
  assign o_Right_Index = wrap_inc(pos_q);
  assign o_Update      = upd_q;
  assign o_Mode        = (state_q == S_AUTO) || ((state_q == S_HOLD) && ret_auto_q);

endmodule

// File: doc/scroll_controller.md
SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 The block SHALL have parameter TICKS_PER_STEP, default 25000000, meaning i_Clk cycles between automatic advances (1 s at 25 MHz).
REQ-002 The block SHALL have parameter MSG_LEN, default 16, meaning the number of characters in the message (legal range 2..32).
REQ-003 The block SHALL have port i_Clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port i_Step  input  1  single-cycle pulse from the debounced switch: manual advance.
REQ-006 The block SHALL have port i_Run  input  1  single-cycle pulse that toggles between MANUAL and AUTO modes.
REQ-007 The block SHALL have port i_Hold  input  1  level signal that freezes scrolling while high.
REQ-008 The block SHALL have port o_Left_Index  output  5  character index for the left digit, which is the message position.
REQ-009 The block SHALL have port o_Right_Index  output  5  character index for the right digit, equal to (position+1) mod MSG_LEN.
REQ-010 The block SHALL have port o_Update  output  1  one-cycle pulse in the same cycle in which the indices take new values.
REQ-011 The block SHALL have port o_Mode  output  1  1 = AUTO, 0 = MANUAL; reflects the non-hold mode.

Function
REQ-012 The FSM SHALL have states S_MANUAL, S_AUTO and S_HOLD, plus a registered "return mode" bit used when leaving S_HOLD.
REQ-013 In S_MANUAL, an i_Step pulse SHALL advance the position one cycle later (registered, latency 1).
REQ-014 In S_MANUAL, an i_Run pulse SHALL move the FSM to S_AUTO and clear the tick counter.
REQ-015 In S_AUTO, the tick counter SHALL count 0..TICKS_PER_STEP-1; reaching TICKS_PER_STEP-1 SHALL advance the position and wrap the counter to 0.
REQ-016 In S_AUTO, an i_Step pulse SHALL also advance the position and clear the counter.
REQ-017 In S_AUTO, an i_Run pulse SHALL return the FSM to S_MANUAL and clear the counter.
REQ-018 From S_MANUAL or S_AUTO, i_Hold high SHALL enter S_HOLD and record the return mode.
REQ-019 In S_HOLD, the position, the counter and o_Mode SHALL be frozen; i_Step and i_Run SHALL be ignored (discarded).
REQ-020 i_Hold low SHALL return the FSM to the recorded mode with the counter resuming from its frozen value.
REQ-021 An advance SHALL set position to position+1, or to 0 when position = MSG_LEN-1; o_Right_Index SHALL use the same wrap rule.
REQ-022 Simultaneous events SHALL resolve as: i_Hold over i_Run over i_Step; a tick and i_Step in the same cycle SHALL produce exactly one advance.
REQ-023 o_Update SHALL be high only in cycles in which the indices change; it SHALL never be high for 2 consecutive cycles unless consecutive advances occur.
REQ-024 Arithmetic SHALL be unsigned; the counter width SHALL be clog2(TICKS_PER_STEP), minimum 1.

Reset
REQ-025 i_Reset high at any clock edge, including mid-count or in S_HOLD, SHALL force: state S_MANUAL, position 0, o_Left_Index 0, o_Right_Index 1, counter 0, o_Mode 0, o_Update 0, return mode MANUAL.
REQ-026 Reset SHALL take priority over all other inputs in the same cycle.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (S_MANUAL=0, S_AUTO=1, S_HOLD=2), the index width (5), and the default TICKS_PER_STEP and MSG_LEN values.
REQ-028 The tick counter SHALL be a sub-module tick_divider with enable, clear and a terminal-count pulse output; the FSM and the position register SHALL stay in scroll_controller.

Verification (TICKS_PER_STEP=4, MSG_LEN=6)
REQ-029 Reset test: hold i_Reset for 2 cycles -> indices 0/1, o_Mode 0, o_Update 0.
REQ-030 Manual wrap test: apply 6 i_Step pulses spaced 3 cycles apart -> indices 1/2, 2/3, 3/4, 4/5, 5/0, 0/1, with one o_Update per step.
REQ-031 Auto test: pulse i_Run -> o_Mode 1; with no other input, indices advance every 4 cycles; pulse i_Run again -> o_Mode 0 and advancing stops.
REQ-032 Hold test: in AUTO with the counter at 2, raise i_Hold for 10 cycles while also pulsing i_Step and i_Run -> no index change and o_Mode stays 1; after release, the next advance occurs 2 cycles later.
REQ-033 Collision test: in AUTO, pulse i_Step in the terminal-count cycle -> a single advance; in MANUAL, pulse i_Run and i_Step together -> mode toggles to AUTO with no advance.
REQ-034 Reset mid-operation test: in AUTO at position 4, pulse i_Reset -> indices 0/1, o_Mode 0, and no further auto advance occurs.
